systolic_array_ctrl: RTL and testbench

- Sequencer for a ROWS x COLS output-stationary systolic array of multiply-accumulate PEs.
- Per job it clears the PE accumulators and streams kLen operand steps, with zero-padding so the skewed wavefront reaches the far corner PE.
- It then drains the accumulators out of the bottom row using the PEs' shift-out chain, with ready/valid backpressure.
- It sits between the operand buffers/skew delay lines and the array, and drives the array-wide clear, multiply-enable and shift-enable controls.

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/systolic_array_ctrl.sv | 117 +++++++++++
 tb/tb_systolic_array_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array sequencer.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        COMPUTE,
        DRAIN,
        DONE
    } ctrl_state_t;

    // Operand steps plus the skew needed for the wavefront to reach the far corner PE.
    function automatic int unsigned computeCycles(
        input int unsigned k_len,
        input int unsigned rows,
        input int unsigned cols
    );
        return k_len + rows + cols - 2;
    endfunction

endpackage

// File: rtl/systolic_array_ctrl.sv
// Job sequencer for an output-stationary systolic array: clear, stream operands, drain results.
// state   | meaning
// IDLE    | waiting for start; kLen latched on accept
// CLEAR   | one-cycle synchronous clear of all PE accumulators
// COMPUTE | kLen feed steps followed by zero padding until the wavefront settles
// DRAIN   | shift accumulators out of the bottom row, one row per accepted beat
// DONE    | one-cycle completion pulse
module systolic_array_ctrl
    import systolic_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int K_W  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [K_W-1:0]          kLen,
    output logic                    busy,
    output logic                    done,
    output logic                    peClear,
    output logic                    enableMul,
    output logic                    enableShiftOut,
    output logic                    feedValid,
    output logic [K_W-1:0]          feedIdx,
    output logic                    feedZero,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [$clog2(ROWS)-1:0] outRow
);

    localparam int RW    = $clog2(ROWS);
    localparam int CNT_W = ((K_W > RW) ? K_W : RW) + 1;

    ctrl_state_t      r_state;
    ctrl_state_t      w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [K_W-1:0]   r_klen;
    logic [K_W-1:0]   r_feed_idx;

    logic [CNT_W-1:0] w_cmp_last;
    logic             w_feeding;
    logic             w_comp_end;
    logic             w_last_beat;

    // Bound is formed at CNT_W bits so the largest kLen cannot wrap.
    assign w_cmp_last  = CNT_W'(computeCycles(32'(r_klen), ROWS, COLS) - 1);
    assign w_feeding   = (r_state == COMPUTE) && (r_cnt < CNT_W'(r_klen));
    assign w_comp_end  = (r_cnt == w_cmp_last);
    assign w_last_beat = (r_cnt == CNT_W'(ROWS - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_klen     <= '0;
            r_feed_idx <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_klen <= kLen;
            end
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_state == COMPUTE || (r_state == DRAIN && outReady)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_feeding) begin
                r_feed_idx <= r_cnt[K_W-1:0];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = CLEAR;
            CLEAR:   w_next = (r_klen == '0) ? DRAIN : COMPUTE;
            COMPUTE: if (w_comp_end) w_next = DRAIN;
            DRAIN:   if (outReady && w_last_beat) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy           = (r_state != IDLE);
        done           = 1'b0;
        peClear        = 1'b0;
        enableMul      = 1'b0;
        enableShiftOut = 1'b0;
        feedValid      = 1'b0;
        feedZero       = 1'b0;
        feedIdx        = r_feed_idx;
        outValid       = 1'b0;
        outRow         = '0;
        case (r_state)
            CLEAR: peClear = 1'b1;
            COMPUTE: begin
                enableMul = 1'b1;
                feedValid = w_feeding;
                feedZero  = !w_feeding;
                if (w_feeding) begin
                    feedIdx = r_cnt[K_W-1:0];
                end
            end
            DRAIN: begin
                outValid       = 1'b1;
                enableShiftOut = outReady;
                outRow         = r_cnt[RW-1:0];
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl on a 4x4 array.
module tb_systolic_array_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int K_W  = 16;

    // {busy, done, peClear, enableMul, enableShiftOut, feedValid, feedZero, outValid}
    localparam logic [7:0] C_IDLE  = 8'h00;
    localparam logic [7:0] C_CLEAR = 8'hA0;
    localparam logic [7:0] C_FEED  = 8'h94;
    localparam logic [7:0] C_PAD   = 8'h92;
    localparam logic [7:0] C_BEAT  = 8'h89;
    localparam logic [7:0] C_STALL = 8'h81;
    localparam logic [7:0] C_DONE  = 8'hC0;

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    logic                    start = 1'b0;
    logic [K_W-1:0]          kLen = '0;
    logic                    outReady = 1'b0;
    logic                    busy, done, peClear, enableMul, enableShiftOut;
    logic                    feedValid, feedZero, outValid;
    logic [K_W-1:0]          feedIdx;
    logic [$clog2(ROWS)-1:0] outRow;
    logic [7:0]              ctl;

    int tests = 0;
    int fails = 0;

    systolic_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_W(K_W)) dut (
        .clock(clock), .reset(reset), .start(start), .kLen(kLen),
        .busy(busy), .done(done), .peClear(peClear), .enableMul(enableMul),
        .enableShiftOut(enableShiftOut), .feedValid(feedValid), .feedIdx(feedIdx),
        .feedZero(feedZero), .outValid(outValid), .outReady(outReady), .outRow(outRow)
    );

    always #5 clock = ~clock;

    assign ctl = {busy, done, peClear, enableMul, enableShiftOut, feedValid, feedZero, outValid};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    // Accept a job and run through CLEAR and COMPUTE; returns with DRAIN's first cycle next.
    task automatic run_to_drain(input logic [K_W-1:0] k, input string tag);
        int muls = 0;
        int len;
        logic [K_W-1:0] last_idx = '0;
        len = (k == '0) ? 0 : int'(k) + ROWS + COLS - 2;
        cyc(); start = 1'b1; kLen = k; #1;
        chk({tag, "_idle"}, 32'(ctl), 32'(C_IDLE));
        cyc(); start = 1'b0; #1;
        chk({tag, "_clear"}, 32'(ctl), 32'(C_CLEAR));
        for (int i = 0; i < len; i++) begin
            cyc(); #1;
            if (enableMul) muls++;
            if (feedValid) last_idx = feedIdx;
        end
        chk({tag, "_mul_len"}, 32'(muls), 32'(len));
        if (k != '0) chk({tag, "_last_idx"}, 32'(last_idx), 32'(k) - 1);
    endtask

    task automatic drain_all(input string tag);
        for (int r = 0; r < ROWS; r++) begin
            cyc(); #1;
            chk({tag, "_beat"}, 32'(ctl), 32'(C_BEAT));
            chk({tag, "_row"}, 32'(outRow), 32'(r));
        end
        cyc(); #1;
        chk({tag, "_done"}, 32'(ctl), 32'(C_DONE));
        cyc(); #1;
        chk({tag, "_after"}, 32'(ctl), 32'(C_IDLE));
    endtask

    initial begin
        int rdy[7]  = '{1, 0, 0, 1, 1, 0, 1};
        int rows[7] = '{0, 1, 1, 1, 2, 3, 3};
        int muls;

        #1;
        chk("reset_ctl", 32'(ctl), 32'(C_IDLE));
        chk("reset_row", 32'(outRow), 32'd0);
        chk("reset_idx", 32'(feedIdx), 32'd0);
        cyc(); cyc();
        reset = 1'b1;
        outReady = 1'b1;

        // Basic job, kLen=8: 14 compute cycles, 8 fed then 6 padded
        cyc(); start = 1'b1; kLen = 16'd8; #1;
        chk("basic_idle", 32'(ctl), 32'(C_IDLE));
        cyc(); start = 1'b0; #1;
        chk("basic_clear", 32'(ctl), 32'(C_CLEAR));
        for (int i = 0; i < 14; i++) begin
            cyc(); #1;
            chk("basic_cmp_ctl", 32'(ctl), 32'((i < 8) ? C_FEED : C_PAD));
            chk("basic_cmp_idx", 32'(feedIdx), (i < 8) ? 32'(i) : 32'd7);
        end
        drain_all("basic");

        // Backpressure during drain
        run_to_drain(16'd8, "bp");
        for (int i = 0; i < 7; i++) begin
            cyc(); outReady = rdy[i][0]; #1;
            chk("bp_ctl", 32'(ctl), 32'((rdy[i] != 0) ? C_BEAT : C_STALL));
            chk("bp_row", 32'(outRow), 32'(rows[i]));
        end
        cyc(); outReady = 1'b1; #1;
        chk("bp_done", 32'(ctl), 32'(C_DONE));
        cyc(); #1;
        chk("bp_after", 32'(ctl), 32'(C_IDLE));

        // kLen=0 goes CLEAR -> DRAIN
        run_to_drain(16'd0, "k0");
        drain_all("k0");

        // Asynchronous reset in the middle of COMPUTE
        cyc(); start = 1'b1; kLen = 16'd8; #1;
        cyc(); start = 1'b0; #1;
        for (int i = 0; i < 5; i++) cyc();
        #1;
        chk("rst_pre_ctl", 32'(ctl), 32'(C_FEED));
        chk("rst_pre_idx", 32'(feedIdx), 32'd4);
        #1; reset = 1'b0; #1;
        chk("rst_async_ctl", 32'(ctl), 32'(C_IDLE));
        chk("rst_async_idx", 32'(feedIdx), 32'd0);
        chk("rst_async_row", 32'(outRow), 32'd0);
        cyc(); reset = 1'b1;
        run_to_drain(16'd3, "rst_job");
        drain_all("rst_job");

        // start held high throughout; kLen changed mid-job
        cyc(); start = 1'b1; kLen = 16'd2; #1;
        cyc(); kLen = 16'd9; #1;
        chk("hold_clear", 32'(ctl), 32'(C_CLEAR));
        muls = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(); #1;
            if (enableMul) muls++;
        end
        chk("hold_mul_len", 32'(muls), 32'd8);
        for (int r = 0; r < ROWS; r++) begin
            cyc(); #1;
            chk("hold_row", 32'(outRow), 32'(r));
        end
        cyc(); #1;
        chk("hold_done", 32'(ctl), 32'(C_DONE));
        cyc(); #1;
        chk("hold_bubble", 32'(ctl), 32'(C_IDLE));
        cyc(); start = 1'b0; #1;
        chk("hold_clear2", 32'(ctl), 32'(C_CLEAR));
        muls = 0;
        for (int i = 0; i < 15; i++) begin
            cyc(); #1;
            if (enableMul) muls++;
        end
        chk("hold_mul_len2", 32'(muls), 32'd15);
        drain_all("hold2");

        // Largest kLen: no counter wrap
        run_to_drain(16'hFFFF, "big");
        chk("big_idx_held", 32'(feedIdx), 32'h0000_FFFE);
        drain_all("big");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
